// File: rtl/gpu_tex_pkg.sv
// Shared texturing definitions: texel formats and VRAM address composition constants.
package gpu_tex_pkg;

  typedef enum logic [1:0] {
    PIX_4BIT     = 2'd0,
    PIX_8BIT     = 2'd1,
    PIX_16BIT    = 2'd2,
    PIX_RESERVED = 2'd3
  } texFormat_t;

  // Halfword address = {pageY, Vt, adrX}; adrX is always 10 bits wide.
  localparam int TEXPAGE_X_SHIFT = 6;
  localparam int ADRX_W          = 10;
  localparam int PAGEY_W         = 1;

endpackage

// File: rtl/tex_lane_adr.sv
// Per-lane combinational texel addressing: window apply on raw coords, and
// format shift / page base add / sub-halfword select on stage-1 coords.
module tex_lane_adr
  import gpu_tex_pkg::*;
#(
  parameter int COORD_W = 8,
  parameter int ADDR_W  = 19
) (
  input  logic [COORD_W-1:0] i_u,
  input  logic [COORD_W-1:0] i_v,
  input  logic [COORD_W-4:0] i_maskX,
  input  logic [COORD_W-4:0] i_maskY,
  input  logic [COORD_W-4:0] i_offX,
  input  logic [COORD_W-4:0] i_offY,
  output logic [COORD_W-1:0] o_ut,
  output logic [COORD_W-1:0] o_vt,
  input  logic [COORD_W-1:0] i_s1Ut,
  input  logic [COORD_W-1:0] i_s1Vt,
  input  logic [3:0]         i_pageX,
  input  logic               i_pageY,
  input  logic [1:0]         i_fmt,
  output logic [ADDR_W-1:0]  o_adr,
  output logic [1:0]         o_subSel
);

  logic [ADRX_W-1:0] w_base;
  logic [ADRX_W-1:0] w_utExt;
  logic [ADRX_W-1:0] w_step;
  logic [ADRX_W-1:0] w_adrX;

  assign o_ut = (i_u & ~{i_maskX, 3'b000}) | {i_offX & i_maskX, 3'b000};
  assign o_vt = (i_v & ~{i_maskY, 3'b000}) | {i_offY & i_maskY, 3'b000};

  assign w_base  = ADRX_W'(i_pageX) << TEXPAGE_X_SHIFT;
  assign w_utExt = ADRX_W'(i_s1Ut);

  // Texels per halfword: 4 at 4bpp, 2 at 8bpp, 1 otherwise.
  always_comb begin
    w_step   = w_utExt;
    o_subSel = 2'b00;
    case (i_fmt)
      PIX_4BIT: begin
        w_step   = w_utExt >> 2;
        o_subSel = i_s1Ut[1:0];
      end
      PIX_8BIT: begin
        w_step   = w_utExt >> 1;
        o_subSel = {1'b0, i_s1Ut[0]};
      end
      default: begin
        w_step   = w_utExt;
        o_subSel = 2'b00;
      end
    endcase
  end

  // adrX wraps modulo 1024 by construction of the 10-bit sum.
  assign w_adrX = w_base + w_step;
  assign o_adr  = {i_pageY, i_s1Vt, w_adrX};

endmodule

// File: rtl/tex_addr_pipe.sv
// Two-stage multi-lane texel address pipeline (window, then address) with
// full-throughput valid/ready handshake; config travels with each beat.
module tex_addr_pipe
  import gpu_tex_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int COORD_W   = 8,
  parameter int ADDR_W    = 19
) (
  input  logic                           clk,
  input  logic                           i_nrst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [3:0]                     i_texBasePageX,
  input  logic                           i_texBasePageY,
  input  logic [1:0]                     i_texFormat,
  input  logic [COORD_W-4:0]             i_winMaskX,
  input  logic [COORD_W-4:0]             i_winMaskY,
  input  logic [COORD_W-4:0]             i_winOffX,
  input  logic [COORD_W-4:0]             i_winOffY,
  input  logic [NUM_LANES*COORD_W-1:0]   i_coordU,
  input  logic [NUM_LANES*COORD_W-1:0]   i_coordV,
  input  logic [NUM_LANES-1:0]           i_laneEn,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [NUM_LANES*ADDR_W-1:0]    o_texelAdr,
  output logic [NUM_LANES*2-1:0]         o_subSel,
  output logic [NUM_LANES-1:0]           o_laneEn,
  output logic [NUM_LANES-1:0]           o_sameHW
);

  logic                         r_s1Valid;
  logic [NUM_LANES*COORD_W-1:0] r_s1Ut;
  logic [NUM_LANES*COORD_W-1:0] r_s1Vt;
  logic [3:0]                   r_s1PageX;
  logic                         r_s1PageY;
  logic [1:0]                   r_s1Fmt;
  logic [NUM_LANES-1:0]         r_s1LaneEn;

  logic                         r_s2Valid;
  logic [NUM_LANES*ADDR_W-1:0]  r_s2Adr;
  logic [NUM_LANES*2-1:0]       r_s2SubSel;
  logic [NUM_LANES-1:0]         r_s2LaneEn;
  logic [NUM_LANES-1:0]         r_s2SameHW;

  logic [NUM_LANES*COORD_W-1:0] w_ut;
  logic [NUM_LANES*COORD_W-1:0] w_vt;
  logic [NUM_LANES*ADDR_W-1:0]  w_adr;
  logic [NUM_LANES*2-1:0]       w_subSel;
  logic [NUM_LANES-1:0]         w_sameHW;
  logic                         w_adv1;
  logic                         w_adv2;
  logic                         w_accept;

  assign w_adv2   = !r_s2Valid || i_ready;
  assign w_adv1   = !r_s1Valid || w_adv2;
  assign w_accept = i_valid && w_adv1;
  assign o_ready  = w_adv1;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    tex_lane_adr #(
      .COORD_W (COORD_W),
      .ADDR_W  (ADDR_W)
    ) u_lane (
      .i_u      (i_coordU[g*COORD_W +: COORD_W]),
      .i_v      (i_coordV[g*COORD_W +: COORD_W]),
      .i_maskX  (i_winMaskX),
      .i_maskY  (i_winMaskY),
      .i_offX   (i_winOffX),
      .i_offY   (i_winOffY),
      .o_ut     (w_ut[g*COORD_W +: COORD_W]),
      .o_vt     (w_vt[g*COORD_W +: COORD_W]),
      .i_s1Ut   (r_s1Ut[g*COORD_W +: COORD_W]),
      .i_s1Vt   (r_s1Vt[g*COORD_W +: COORD_W]),
      .i_pageX  (r_s1PageX),
      .i_pageY  (r_s1PageY),
      .i_fmt    (r_s1Fmt),
      .o_adr    (w_adr[g*ADDR_W +: ADDR_W]),
      .o_subSel (w_subSel[g*2 +: 2])
    );
  end

  // Merge hint: neighbouring enabled lanes hitting the same halfword.
  always_comb begin
    w_sameHW = {NUM_LANES{1'b0}};
    for (int i = 1; i < NUM_LANES; i++) begin
      w_sameHW[i] = r_s1LaneEn[i] && r_s1LaneEn[i-1] &&
                    (w_adr[i*ADDR_W +: ADDR_W] == w_adr[(i-1)*ADDR_W +: ADDR_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      r_s1Valid <= 1'b0;
    end else if (w_adv1) begin
      r_s1Valid <= i_valid;
    end else begin
      r_s1Valid <= r_s1Valid;
    end
  end

  // Stage-1 payload needs no reset; it is qualified by r_s1Valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1Ut     <= w_ut;
      r_s1Vt     <= w_vt;
      r_s1PageX  <= i_texBasePageX;
      r_s1PageY  <= i_texBasePageY;
      r_s1Fmt    <= i_texFormat;
      r_s1LaneEn <= i_laneEn;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      r_s2Valid  <= 1'b0;
      r_s2Adr    <= {(NUM_LANES*ADDR_W){1'b0}};
      r_s2SubSel <= {(NUM_LANES*2){1'b0}};
      r_s2LaneEn <= {NUM_LANES{1'b0}};
      r_s2SameHW <= {NUM_LANES{1'b0}};
    end else if (w_adv2) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Adr    <= w_adr;
        r_s2SubSel <= w_subSel;
        r_s2LaneEn <= r_s1LaneEn;
        r_s2SameHW <= w_sameHW;
      end
    end
  end

  assign o_valid    = r_s2Valid;
  assign o_texelAdr = r_s2Adr;
  assign o_subSel   = r_s2SubSel;
  assign o_laneEn   = r_s2LaneEn;
  assign o_sameHW   = r_s2SameHW;

endmodule
